// File: rtl/fm_pkg.sv
// Shared helpers for the FM modulator: constant functions and sample-format codes.
package fm_pkg;

  localparam int unsigned SIGNED        = 1;
  localparam int unsigned OFFSET_BINARY = 0;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    longint unsigned v;
    r = 0;
    v = 1;
    while (v < longint'(value)) begin
      v = v << 1;
      r++;
    end
    return r;
  endfunction

  function automatic int unsigned calc_divider(input int unsigned clock_rate,
                                               input int unsigned sample_rate);
    return clock_rate / sample_rate;
  endfunction

  // Rounded 2^phase_bits * freq / clock_rate.
  function automatic longint unsigned calc_carrier_delta(input int unsigned phase_bits,
                                                         input int unsigned freq,
                                                         input int unsigned clock_rate);
    longint unsigned num;
    longint unsigned den;
    num = (longint'(1) << phase_bits) * longint'(freq);
    den = longint'(clock_rate);
    return (num + den / 2) / den;
  endfunction

endpackage

// File: rtl/sample_fifo.sv
// Synchronous FIFO with registered level; push ignored when full, pop ignored when empty.
module sample_fifo
  import fm_pkg::*;
#(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  push_i,
  input  logic                  pop_i,
  input  logic [Width-1:0]      data_i,
  output logic [Width-1:0]      data_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [clog2(Depth):0] level_o
);

  localparam int unsigned AddrW = clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [AddrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AddrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AddrW:0]   level_q, level_d;
  logic             do_push, do_pop;

  always_comb begin
    full_o   = (level_q == (AddrW + 1)'(Depth));
    empty_o  = (level_q == '0);
    do_push  = push_i && !full_o;
    do_pop   = pop_i && !empty_o;
    wr_ptr_d = do_push ? wr_ptr_q + AddrW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop ? rd_ptr_q + AddrW'(1) : rd_ptr_q;
    level_d  = level_q + (AddrW + 1)'(do_push) - (AddrW + 1)'(do_pop);
    data_o   = mem_q[rd_ptr_q];
    level_o  = level_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/fm_modulator_nco.sv
// FM modulator: buffered samples paced at sampleRate offset the increment of a phase
// accumulator whose MSB is the RF square wave.
module fm_modulator_nco
  import fm_pkg::*;
#(
  parameter int unsigned clockRate      = 307_200_000,
  parameter int unsigned sampleRate     = 48_000,
  parameter int unsigned frequency      = 106_500_000,
  parameter int unsigned phaseBits      = 32,
  parameter int unsigned sampleBits     = 24,
  parameter int unsigned deviationShift = 8,
  parameter int unsigned fifoDepth      = 16,
  parameter int unsigned signedSamples  = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      inValid,
  input  logic [sampleBits-1:0]     inData,
  output logic                      inReady,
  output logic                      rf,
  output logic [phaseBits-1:0]      phase,
  output logic                      sampleTick,
  output logic                      underrun,
  output logic [clog2(fifoDepth):0] fifoLevel
);

  localparam int unsigned Divider = calc_divider(clockRate, sampleRate);
  localparam int unsigned CntW    = clog2(Divider);
  localparam logic [phaseBits-1:0] CarrierDelta =
      phaseBits'(calc_carrier_delta(phaseBits, frequency, clockRate));

  if (sampleBits + deviationShift > phaseBits) begin : g_err_width
    $error("sampleBits + deviationShift must not exceed phaseBits");
  end
  if (fifoDepth < 2 || (fifoDepth & (fifoDepth - 1)) != 0) begin : g_err_depth
    $error("fifoDepth must be a power of 2 and at least 2");
  end
  if (Divider < 2) begin : g_err_divider
    $error("clockRate / sampleRate must be at least 2");
  end

  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [phaseBits-1:0]  phase_q, phase_d;
  logic [phaseBits-1:0]  delta_q, delta_d;
  logic                  underrun_q, underrun_d;

  logic                  fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [sampleBits-1:0] fifo_head;
  logic [sampleBits-1:0] samp_adj;
  logic [phaseBits-1:0]  samp_ext, offset;

  sample_fifo #(
    .Width (sampleBits),
    .Depth (fifoDepth)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (reset),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .data_i  (inData),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifoLevel)
  );

  // Offset-binary becomes two's complement by inverting the MSB.
  always_comb begin
    samp_adj = fifo_head;
    if (signedSamples == OFFSET_BINARY) begin
      samp_adj[sampleBits-1] = ~fifo_head[sampleBits-1];
    end
    samp_ext                   = {phaseBits{samp_adj[sampleBits-1]}};
    samp_ext[sampleBits-1:0]   = samp_adj;
    offset                     = samp_ext << deviationShift;
  end

  always_comb begin
    inReady    = !reset && !fifo_full;
    fifo_push  = inValid && inReady;
    sampleTick = enable && (cnt_q == CntW'(Divider - 1));
    fifo_pop   = sampleTick && !fifo_empty;

    cnt_d      = '0;
    phase_d    = phase_q;
    delta_d    = delta_q;
    underrun_d = underrun_q;

    if (enable) begin
      phase_d = phase_q + delta_q;
      if (!sampleTick) begin
        cnt_d = cnt_q + CntW'(1);
      end
    end

    if (sampleTick) begin
      if (fifo_empty) begin
        delta_d    = CarrierDelta;
        underrun_d = 1'b1;
      end else begin
        delta_d = CarrierDelta + offset;
      end
    end

    rf       = enable && phase_q[phaseBits-1];
    phase    = phase_q;
    underrun = underrun_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q      <= '0;
      phase_q    <= '0;
      delta_q    <= CarrierDelta;
      underrun_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      phase_q    <= phase_d;
      delta_q    <= delta_d;
      underrun_q <= underrun_d;
    end
  end

endmodule

// File: tb/tb_fm_modulator_nco.sv
// Bench for fm_modulator_nco: two instances (signed and offset-binary samples) share stimulus
// and are checked every cycle against a queue-based model, plus hand-computed expectations.
module tb_fm_modulator_nco;

  localparam int Carrier = 8192;
  localparam int Div     = 10;
  localparam int Depth   = 4;

  logic        clk;
  logic        reset, enable, in_valid;
  logic [7:0]  in_data;
  logic        in_ready_s, in_ready_o, rf_s, rf_o, tick_s, tick_o, und_s, und_o;
  logic [15:0] phase_s, phase_o;
  logic [2:0]  level_s, level_o;

  int n_vec;
  int n_err;

  fm_modulator_nco #(
    .clockRate(1000), .sampleRate(100), .frequency(125), .phaseBits(16), .sampleBits(8),
    .deviationShift(4), .fifoDepth(4), .signedSamples(1)
  ) u_dut_s (
    .clk(clk), .reset(reset), .enable(enable), .inValid(in_valid), .inData(in_data),
    .inReady(in_ready_s), .rf(rf_s), .phase(phase_s), .sampleTick(tick_s),
    .underrun(und_s), .fifoLevel(level_s)
  );

  fm_modulator_nco #(
    .clockRate(1000), .sampleRate(100), .frequency(125), .phaseBits(16), .sampleBits(8),
    .deviationShift(4), .fifoDepth(4), .signedSamples(0)
  ) u_dut_o (
    .clk(clk), .reset(reset), .enable(enable), .inValid(in_valid), .inData(in_data),
    .inReady(in_ready_o), .rf(rf_o), .phase(phase_o), .sampleTick(tick_o),
    .underrun(und_o), .fifoLevel(level_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: index 0 = signed instance, 1 = offset-binary instance.
  logic [7:0] m_q[$];
  int         m_cnt;
  bit         m_und;
  int         m_phase[2];
  int         m_delta[2];
  bit         m_valid;

  task automatic check_cycle();
    bit exp_ready;
    bit exp_tick;
    exp_ready = !reset && (m_q.size() < Depth);
    exp_tick  = enable && (m_cnt == Div - 1);
    chk("inReady_s", 32'(in_ready_s), 32'(exp_ready));
    chk("inReady_o", 32'(in_ready_o), 32'(exp_ready));
    chk("tick_s", 32'(tick_s), 32'(exp_tick));
    chk("tick_o", 32'(tick_o), 32'(exp_tick));
    chk("underrun_s", 32'(und_s), 32'(m_und));
    chk("underrun_o", 32'(und_o), 32'(m_und));
    chk("level_s", 32'(level_s), 32'(m_q.size()));
    chk("level_o", 32'(level_o), 32'(m_q.size()));
    chk("phase_s", 32'(phase_s), 32'(m_phase[0]));
    chk("phase_o", 32'(phase_o), 32'(m_phase[1]));
    chk("rf_s", 32'(rf_s), 32'(enable && m_phase[0] >= 32768));
    chk("rf_o", 32'(rf_o), 32'(enable && m_phase[1] >= 32768));
  endtask

  task automatic model_step();
    bit         push;
    bit         tick;
    logic [7:0] s;
    byte        sb;
    if (reset) begin
      m_q.delete();
      m_cnt   = 0;
      m_und   = 0;
      m_phase = '{0, 0};
      m_delta = '{Carrier, Carrier};
      m_valid = 1;
      return;
    end
    if (!m_valid) return;
    push = in_valid && (m_q.size() < Depth);
    tick = enable && (m_cnt == Div - 1);
    if (enable) begin
      for (int m = 0; m < 2; m++) m_phase[m] = (m_phase[m] + m_delta[m]) % 65536;
    end
    if (tick) begin
      if (m_q.size() > 0) begin
        s          = m_q.pop_front();
        sb         = s;
        m_delta[0] = (Carrier + int'(sb) * 16) & 32'hFFFF;
        m_delta[1] = (Carrier + (int'(s) - 128) * 16) & 32'hFFFF;
      end else begin
        m_delta = '{Carrier, Carrier};
        m_und   = 1;
      end
    end
    if (push) m_q.push_back(in_data);
    m_cnt = (!enable || tick) ? 0 : m_cnt + 1;
  endtask

  initial begin
    m_valid = 0;
    forever begin
      @(negedge clk);
      #2;
      if (m_valid) check_cycle();
      model_step();
    end
  end

  task automatic drive(input bit r, input bit e, input bit v, input logic [7:0] d);
    @(negedge clk);
    reset    = r;
    enable   = e;
    in_valid = v;
    in_data  = d;
    #3;
  endtask

  task automatic wait_tick(input string name);
    int n;
    n = 0;
    do begin
      drive(0, 1, 0, 8'h00);
      n++;
    end while (!tick_s && n < 25);
    chk(name, 32'(tick_s), 32'd1);
  endtask

  // Called in a tick cycle: returns the phase step that uses the delta loaded by that tick.
  task automatic measure_step(output logic [15:0] ds, output logic [15:0] dov);
    logic [15:0] ps, po;
    drive(0, 1, 0, 8'h00);
    ps = phase_s;
    po = phase_o;
    drive(0, 1, 0, 8'h00);
    ds  = phase_s - ps;
    dov = phase_o - po;
  endtask

  initial begin
    logic [15:0] ds, dov, ph_s, ph_o, p0;
    int          first_tick, second_tick, n;
    int          dens;
    n_vec    = 0;
    n_err    = 0;
    reset    = 1'b1;
    enable   = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;

    // Reset state and free-running carrier with no samples.
    drive(1, 0, 0, 8'h00);
    drive(1, 0, 0, 8'h00);
    drive(0, 1, 0, 8'h00);
    chk("rst_phase", 32'(phase_s), 32'd0);
    chk("rst_level", 32'(level_s), 32'd0);
    chk("rst_underrun", 32'(und_s), 32'd0);
    chk("rst_rf", 32'(rf_s), 32'd0);
    chk("rst_tick", 32'(tick_s), 32'd0);
    first_tick  = -1;
    second_tick = -1;
    p0          = phase_s;
    for (int i = 1; i < 25; i++) begin
      drive(0, 1, 0, 8'h00);
      if (i == 1) chk("carrier_step", 32'(phase_s - p0), 32'd8192);
      if (i == 4) chk("rf_half_period", 32'(rf_s), 32'd1);
      if (i == 10) chk("underrun_after_tick", 32'(und_s), 32'd1);
      if (tick_s && first_tick < 0) first_tick = i;
      else if (tick_s && second_tick < 0) second_tick = i;
    end
    chk("first_tick_cycle", 32'(first_tick), 32'd9);
    chk("tick_period", 32'(second_tick - first_tick), 32'd10);

    // Deviation for signed 0x10 and 0xF0.
    drive(0, 1, 1, 8'h10);
    wait_tick("tick_seen_10");
    measure_step(ds, dov);
    chk("delta_s_10", 32'(ds), 32'd8448);
    chk("delta_o_10", 32'(dov), 32'd6400);
    drive(0, 1, 1, 8'hF0);
    wait_tick("tick_seen_f0");
    measure_step(ds, dov);
    chk("delta_s_f0", 32'(ds), 32'd7936);
    chk("delta_o_f0", 32'(dov), 32'd9984);

    // Fill past capacity with pacing stopped.
    for (int k = 0; k < 5; k++) begin
      drive(0, 0, 1, 8'(k + 1));
      chk("fill_ready", 32'(in_ready_s), 32'(k < 4));
    end
    drive(0, 0, 0, 8'h00);
    chk("fill_level", 32'(level_s), 32'd4);
    wait_tick("tick_seen_full");
    drive(0, 1, 0, 8'h00);
    chk("ready_after_pop", 32'(in_ready_s), 32'd1);
    chk("level_after_pop", 32'(level_s), 32'd3);
    repeat (3) wait_tick("tick_seen_drain");
    drive(0, 1, 0, 8'h00);
    chk("drained_level", 32'(level_s), 32'd0);

    // Empty FIFO at tick with a simultaneous push.
    drive(1, 0, 0, 8'h00);
    drive(1, 0, 0, 8'h00);
    for (int i = 0; i < 9; i++) drive(0, 1, 0, 8'h00);
    drive(0, 1, 1, 8'h20);
    chk("t4_tick", 32'(tick_s), 32'd1);
    chk("t4_underrun_before", 32'(und_s), 32'd0);
    chk("t4_level_before", 32'(level_s), 32'd0);
    drive(0, 1, 0, 8'h00);
    chk("t4_underrun", 32'(und_s), 32'd1);
    chk("t4_level", 32'(level_s), 32'd1);
    p0 = phase_s;
    drive(0, 1, 0, 8'h00);
    chk("t4_carrier_delta", 32'(phase_s - p0), 32'd8192);
    wait_tick("tick_seen_20");
    measure_step(ds, dov);
    chk("delta_s_20", 32'(ds), 32'd8704);
    chk("delta_o_20", 32'(dov), 32'd6656);

    // Disable with two samples queued, then re-enable.
    drive(0, 1, 1, 8'h30);
    drive(0, 1, 1, 8'h40);
    drive(0, 0, 0, 8'h00);
    ph_s = phase_s;
    ph_o = phase_o;
    for (int i = 0; i < 12; i++) begin
      drive(0, 0, 0, 8'h00);
      chk("dis_phase_s", 32'(phase_s), 32'(ph_s));
      chk("dis_phase_o", 32'(phase_o), 32'(ph_o));
      chk("dis_rf", 32'(rf_s), 32'd0);
      chk("dis_level", 32'(level_s), 32'd2);
    end
    n = 0;
    do begin
      drive(0, 1, 0, 8'h00);
      n++;
    end while (!tick_s && n < 25);
    chk("reenable_tick_cycles", 32'(n), 32'd10);
    measure_step(ds, dov);
    chk("delta_s_30", 32'(ds), 32'd8960);
    wait_tick("tick_seen_40");

    // Offset-binary centre and minimum.
    drive(0, 1, 1, 8'h80);
    wait_tick("tick_seen_80");
    measure_step(ds, dov);
    chk("delta_o_80", 32'(dov), 32'd8192);
    chk("delta_s_80", 32'(ds), 32'd6144);
    drive(0, 1, 1, 8'h00);
    wait_tick("tick_seen_00");
    measure_step(ds, dov);
    chk("delta_o_00", 32'(dov), 32'd6144);
    chk("delta_s_00", 32'(ds), 32'd8192);

    // Reset mid-run with data queued.
    drive(0, 1, 1, 8'h11);
    drive(0, 1, 1, 8'h22);
    repeat (3) drive(0, 1, 0, 8'h00);
    drive(1, 1, 1, 8'h33);
    chk("mid_rst_ready", 32'(in_ready_o), 32'd0);
    drive(0, 1, 0, 8'h00);
    chk("mid_rst_phase", 32'(phase_o), 32'd0);
    chk("mid_rst_level", 32'(level_o), 32'd0);
    chk("mid_rst_underrun", 32'(und_o), 32'd0);
    chk("mid_rst_rf", 32'(rf_o), 32'd0);
    chk("mid_rst_ready_after", 32'(in_ready_o), 32'd1);

    // Randomized traffic, checked by the model every cycle.
    dens = 20;
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) dens = int'($urandom_range(0, 40));
      drive($urandom_range(0, 299) == 0, $urandom_range(0, 9) != 0,
            int'($urandom_range(0, 99)) < dens, 8'($urandom));
    end
    drive(0, 1, 0, 8'h00);
    drive(0, 1, 0, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
